// File: rtl/vga_pattern_control_module_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_control_module_if
//  Description : Pixel-stage bus. Carries the sync generator's active flag,
//                addresses and syncs toward the pattern stage, plus the RGB565
//                pixel, realigned syncs and frame pulse back out of it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_control_module_if;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [10:0] Row_Addr_Sig;
  logic        HSYNC_Sig;
  logic        VSYNC_Sig;
  logic        Mode_Step;
  logic [4:0]  Red_Sig;
  logic [5:0]  Green_Sig;
  logic [4:0]  Blue_Sig;
  logic        HSYNC_Out;
  logic        VSYNC_Out;
  logic        Frame_Done;

  // Sync generator / controller side
  modport master (
    output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_Sig, VSYNC_Sig, Mode_Step,
    input  Red_Sig, Green_Sig, Blue_Sig, HSYNC_Out, VSYNC_Out, Frame_Done
  );

  // Pattern stage side
  modport slave (
    input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_Sig, VSYNC_Sig, Mode_Step,
    output Red_Sig, Green_Sig, Blue_Sig, HSYNC_Out, VSYNC_Out, Frame_Done
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_control_module.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_control_module
//  Description : Two-stage RGB565 test-pattern generator for 800x600 VGA.
//                Colour bars, 32x32 checkerboard and a bouncing box; mode and
//                box position change only at frame end.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_control_module #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  wire logic                   vga_clk,
  input  wire logic                   rst,
  vga_pattern_control_module_if.slave vga_io
);

  localparam logic [10:0] c_LAST_COL = 11'(H_ACTIVE - 1);
  localparam logic [10:0] c_LAST_ROW = 11'(V_ACTIVE - 1);
  localparam logic [10:0] c_LIMIT_X  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_LIMIT_Y  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_BOX_SIZE = 11'(BOX_SIZE);
  localparam logic [10:0] c_STEP     = 11'(BOX_STEP);
  localparam int          c_BAR_W    = H_ACTIVE / 8;

  localparam logic [15:0] c_WHITE   = 16'hFFFF;
  localparam logic [15:0] c_YELLOW  = 16'hFFE0;
  localparam logic [15:0] c_CYAN    = 16'h07FF;
  localparam logic [15:0] c_GREEN   = 16'h07E0;
  localparam logic [15:0] c_MAGENTA = 16'hF81F;
  localparam logic [15:0] c_RED     = 16'hF800;
  localparam logic [15:0] c_BLUE    = 16'h001F;
  localparam logic [15:0] c_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Pattern state
  mode_e       mode_q, mode_d;
  logic        pending_q, pending_d;
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;   // 1 = moving +

  // Stage 1
  logic        rdy1_q, hs1_q, vs1_q, fe1_q;
  mode_e       mode1_q;
  logic [2:0]  bar1_q;
  logic        chk1_q, border1_q, box1_q;

  // Stage 2
  logic [15:0] rgb2_q;
  logic        hs2_q, vs2_q, fd2_q;

  // Combinational per-pixel terms
  logic        w_frame_end;
  logic [2:0]  w_bar_idx;
  logic        w_border;
  logic        w_box_hit;
  logic [10:0] w_box_x_end, w_box_y_end;
  logic [15:0] w_rgb;

  logic [10:0] w_col, w_row;
  assign w_col = vga_io.Column_Addr_Sig;
  assign w_row = vga_io.Row_Addr_Sig;

  assign w_frame_end = vga_io.Ready_Sig && (w_col == c_LAST_COL) && (w_row == c_LAST_ROW);

  // Bar index as a threshold chain: the last threshold crossed wins
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_col >= 11'(i * c_BAR_W)) begin
        w_bar_idx = 3'(i);
      end
    end
  end

  assign w_border    = (w_col == 11'd0) || (w_col == c_LAST_COL) ||
                       (w_row == 11'd0) || (w_row == c_LAST_ROW);
  // Box end never exceeds the active width/height, so 11 bits cannot wrap
  assign w_box_x_end = box_x_q + c_BOX_SIZE;
  assign w_box_y_end = box_y_q + c_BOX_SIZE;
  assign w_box_hit   = (w_col >= box_x_q) && (w_col < w_box_x_end) &&
                       (w_row >= box_y_q) && (w_row < w_box_y_end);

  // Mode/pending state register
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      mode_q    <= MODE_BARS;
      pending_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pending_q <= pending_d;
    end
  end

  // Mode advance: a step request (held or same-cycle) commits at frame end only
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q;
    if (w_frame_end) begin
      pending_d = 1'b0;
      if (pending_q || vga_io.Mode_Step) begin
        case (mode_q)
          MODE_BARS:    mode_d = MODE_CHECKER;
          MODE_CHECKER: mode_d = MODE_BOX;
          default:      mode_d = MODE_BARS;
        endcase
      end
    end else if (vga_io.Mode_Step) begin
      pending_d = 1'b1;
    end
  end

  // Box X motion: clamp at either limit and reverse
  always_comb begin
    box_x_d = box_x_q;
    dir_x_d = dir_x_q;
    if (w_frame_end) begin
      if (dir_x_q) begin
        if (box_x_q + c_STEP >= c_LIMIT_X) begin
          box_x_d = c_LIMIT_X;
          dir_x_d = 1'b0;
        end else begin
          box_x_d = box_x_q + c_STEP;
        end
      end else begin
        if (box_x_q <= c_STEP) begin
          box_x_d = 11'd0;
          dir_x_d = 1'b1;
        end else begin
          box_x_d = box_x_q - c_STEP;
        end
      end
    end
  end

  // Box Y motion: same rule as X against the vertical limit
  always_comb begin
    box_y_d = box_y_q;
    dir_y_d = dir_y_q;
    if (w_frame_end) begin
      if (dir_y_q) begin
        if (box_y_q + c_STEP >= c_LIMIT_Y) begin
          box_y_d = c_LIMIT_Y;
          dir_y_d = 1'b0;
        end else begin
          box_y_d = box_y_q + c_STEP;
        end
      end else begin
        if (box_y_q <= c_STEP) begin
          box_y_d = 11'd0;
          dir_y_d = 1'b1;
        end else begin
          box_y_d = box_y_q - c_STEP;
        end
      end
    end
  end

  // Box position/direction registers
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      box_x_q <= 11'd0;
      box_y_q <= 11'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  // Stage 1: capture timing and pixel classification; the mode is captured
  // with the pixel so the frame-end pixel still renders in the old mode
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      rdy1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fe1_q     <= 1'b0;
      mode1_q   <= MODE_BARS;
      bar1_q    <= 3'd0;
      chk1_q    <= 1'b0;
      border1_q <= 1'b0;
      box1_q    <= 1'b0;
    end else begin
      rdy1_q    <= vga_io.Ready_Sig;
      hs1_q     <= vga_io.HSYNC_Sig;
      vs1_q     <= vga_io.VSYNC_Sig;
      fe1_q     <= w_frame_end;
      mode1_q   <= mode_q;
      bar1_q    <= w_bar_idx;
      chk1_q    <= w_col[5] ^ w_row[5];
      border1_q <= w_border;
      box1_q    <= w_box_hit;
    end
  end

  // Colour lookup from stage-1 classification; blanking forces black
  always_comb begin
    w_rgb = c_BLACK;
    if (rdy1_q) begin
      case (mode1_q)
        MODE_BARS: begin
          case (bar1_q)
            3'd0:    w_rgb = c_WHITE;
            3'd1:    w_rgb = c_YELLOW;
            3'd2:    w_rgb = c_CYAN;
            3'd3:    w_rgb = c_GREEN;
            3'd4:    w_rgb = c_MAGENTA;
            3'd5:    w_rgb = c_RED;
            3'd6:    w_rgb = c_BLUE;
            default: w_rgb = c_BLACK;
          endcase
        end
        MODE_CHECKER: w_rgb = chk1_q ? c_BLACK : c_WHITE;
        MODE_BOX: begin
          if (border1_q) begin
            w_rgb = c_WHITE;
          end else if (box1_q) begin
            w_rgb = c_RED;
          end else begin
            w_rgb = c_BLACK;
          end
        end
        default: w_rgb = c_BLACK;
      endcase
    end
  end

  // Stage 2: output registers
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      rgb2_q <= 16'h0000;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      fd2_q  <= 1'b0;
    end else begin
      rgb2_q <= w_rgb;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      fd2_q  <= fe1_q;
    end
  end

  assign vga_io.Red_Sig    = rgb2_q[15:11];
  assign vga_io.Green_Sig  = rgb2_q[10:5];
  assign vga_io.Blue_Sig   = rgb2_q[4:0];
  assign vga_io.HSYNC_Out  = hs2_q;
  assign vga_io.VSYNC_Out  = vs2_q;
  assign vga_io.Frame_Done = fd2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_control_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pattern_control_module
//  Description : Directed bench for the VGA pattern stage: streamed vector
//                table for bars/latency plus hand sequences for mode steps,
//                box bounce and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_control_module;

  localparam logic [15:0] c_WHITE   = 16'hFFFF;
  localparam logic [15:0] c_YELLOW  = 16'hFFE0;
  localparam logic [15:0] c_CYAN    = 16'h07FF;
  localparam logic [15:0] c_GREEN   = 16'h07E0;
  localparam logic [15:0] c_MAGENTA = 16'hF81F;
  localparam logic [15:0] c_RED     = 16'hF800;
  localparam logic [15:0] c_BLUE    = 16'h001F;
  localparam logic [15:0] c_BLACK   = 16'h0000;
  localparam int          c_NVEC    = 14;

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_control_module_if vga_io ();

  vga_pattern_control_module #(
    .H_ACTIVE (800),
    .V_ACTIVE (600),
    .BOX_SIZE (64),
    .BOX_STEP (2)
  ) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .vga_io  (vga_io)
  );

  typedef struct {
    logic        rdy;
    logic [10:0] col;
    logic [10:0] row;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } vec_t;

  vec_t vecs [c_NVEC];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [10:0] col, input logic [10:0] row,
                       input logic hs, input logic vs, input logic ms);
    vga_io.Ready_Sig       = rdy;
    vga_io.Column_Addr_Sig = col;
    vga_io.Row_Addr_Sig    = row;
    vga_io.HSYNC_Sig       = hs;
    vga_io.VSYNC_Sig       = vs;
    vga_io.Mode_Step       = ms;
  endtask

  task automatic idle();
    drive(1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rgb_out();
    return {vga_io.Red_Sig, vga_io.Green_Sig, vga_io.Blue_Sig};
  endfunction

  function automatic logic [15:0] ctl_out();
    return {13'd0, vga_io.HSYNC_Out, vga_io.VSYNC_Out, vga_io.Frame_Done};
  endfunction

  task automatic check_reset_outs(input string nm);
    check({nm, " rgb"}, rgb_out(), c_BLACK);
    check({nm, " hs/vs/fd"}, ctl_out(), 16'b110);
  endtask

  // One pixel in, read its colour two edges later
  task automatic check_px(input string nm, input logic [10:0] col, input logic [10:0] row,
                          input logic [15:0] exp);
    drive(1'b1, col, row, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    step();
    check(nm, rgb_out(), exp);
  endtask

  task automatic frame_end(input logic ms);
    drive(1'b1, 11'd799, 11'd599, 1'b1, 1'b1, ms);
    step();
    idle();
  endtask

  // Frame end with Frame_Done checked one, two and three edges later
  task automatic frame_end_timed(input string nm, input logic ms);
    frame_end(ms);
    check({nm, " fd@1"}, {15'd0, vga_io.Frame_Done}, 16'd0);
    step();
    check({nm, " fd@2"}, {15'd0, vga_io.Frame_Done}, 16'd1);
    step();
    check({nm, " fd@3"}, {15'd0, vga_io.Frame_Done}, 16'd0);
  endtask

  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 11'd799, 11'd599, 1'b1, 1'b1, 1'b0);
      step();
    end
    idle();
  endtask

  initial begin
    // rdy, col, row, hs, vs, expected rgb (mode 0)
    vecs[0]  = '{1'b1, 11'd0,   11'd0,  1'b1, 1'b1, c_WHITE};
    vecs[1]  = '{1'b1, 11'd99,  11'd5,  1'b1, 1'b1, c_WHITE};
    vecs[2]  = '{1'b1, 11'd100, 11'd5,  1'b1, 1'b1, c_YELLOW};
    vecs[3]  = '{1'b1, 11'd150, 11'd10, 1'b0, 1'b1, c_YELLOW};
    vecs[4]  = '{1'b1, 11'd200, 11'd10, 1'b1, 1'b1, c_CYAN};
    vecs[5]  = '{1'b1, 11'd299, 11'd10, 1'b0, 1'b1, c_CYAN};
    vecs[6]  = '{1'b1, 11'd300, 11'd10, 1'b1, 1'b1, c_GREEN};
    vecs[7]  = '{1'b1, 11'd400, 11'd11, 1'b1, 1'b0, c_MAGENTA};
    vecs[8]  = '{1'b1, 11'd500, 11'd11, 1'b1, 1'b1, c_RED};
    vecs[9]  = '{1'b1, 11'd600, 11'd11, 1'b1, 1'b1, c_BLUE};
    vecs[10] = '{1'b1, 11'd700, 11'd11, 1'b1, 1'b1, c_BLACK};
    vecs[11] = '{1'b1, 11'd599, 11'd12, 1'b1, 1'b1, c_RED};
    vecs[12] = '{1'b1, 11'd799, 11'd0,  1'b1, 1'b1, c_BLACK};
    vecs[13] = '{1'b0, 11'd150, 11'd10, 1'b1, 1'b0, c_BLACK};

    // Reset held 5 cycles with random inputs
    rst = 1'b1;
    drive(1'($urandom), 11'($urandom_range(0, 799)), 11'($urandom_range(0, 599)),
          1'($urandom), 1'($urandom), 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check_reset_outs($sformatf("reset c%0d", c));
      drive(1'($urandom), 11'($urandom_range(0, 799)), 11'($urandom_range(0, 599)),
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    rst = 1'b0;
    idle();

    // Streamed table: vector i drives at cycle i, its output lands at i+2
    for (int i = 0; i < c_NVEC + 2; i++) begin
      if (i >= 2) begin
        check($sformatf("vec%0d rgb", i - 2), rgb_out(), vecs[i-2].rgb);
        check($sformatf("vec%0d ctl", i - 2), ctl_out(),
              {13'd0, vecs[i-2].hs, vecs[i-2].vs, 1'b0});
      end
      if (i < c_NVEC) begin
        drive(vecs[i].rdy, vecs[i].col, vecs[i].row, vecs[i].hs, vecs[i].vs, 1'b0);
      end else begin
        idle();
      end
      step();
    end

    // Three step pulses mid-frame: no change until frame end
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 11'd150, 11'd10, 1'b1, 1'b1, 1'b1);
      step();
      idle();
      step();
    end
    check_px("pending still bars", 11'd100, 11'd0, c_YELLOW);
    frame_end_timed("fe1", 1'b0);                               // frames=1, mode 1
    check_px("chk (0,0)",   11'd0,   11'd0,  c_WHITE);
    check_px("chk (100,0)", 11'd100, 11'd0,  c_BLACK);
    check_px("chk (31,0)",  11'd31,  11'd0,  c_WHITE);
    check_px("chk (32,0)",  11'd32,  11'd0,  c_BLACK);
    check_px("chk (32,32)", 11'd32,  11'd32, c_WHITE);
    check_px("chk (0,32)",  11'd0,   11'd32, c_BLACK);
    frame_end(1'b0);                                            // frames=2, single step only
    step();
    check_px("one step only", 11'd100, 11'd0, c_BLACK);
    frame_end(1'b1);                                            // frames=3, mode 2, box (6,6)
    step();
    check_px("box (6,6)",   11'd6,  11'd6, c_RED);
    check_px("box (5,6)",   11'd5,  11'd6, c_BLACK);
    check_px("box (69,6)",  11'd69, 11'd6, c_RED);
    check_px("box (70,6)",  11'd70, 11'd6, c_BLACK);
    check_px("box (6,5)",   11'd6,  11'd5, c_BLACK);
    check_px("border (0,5)", 11'd0, 11'd5, c_WHITE);
    check_px("border (5,0)", 11'd5, 11'd0, c_WHITE);

    run_frames(265);                                            // frames=268, box (536,536)
    check_px("f268 (536,536)", 11'd536, 11'd536, c_RED);
    check_px("f268 (535,536)", 11'd535, 11'd536, c_BLACK);
    check_px("f268 (536,535)", 11'd536, 11'd535, c_BLACK);
    check_px("f268 (537,598)", 11'd537, 11'd598, c_RED);
    check_px("f268 (536,599)", 11'd536, 11'd599, c_WHITE);

    run_frames(100);                                            // frames=368, box (736,336)
    check_px("f368 (736,336)", 11'd736, 11'd336, c_RED);
    check_px("f368 (735,336)", 11'd735, 11'd336, c_BLACK);
    check_px("f368 (798,336)", 11'd798, 11'd336, c_RED);
    check_px("f368 (799,336)", 11'd799, 11'd336, c_WHITE);

    run_frames(1);                                              // frames=369, box (734,334)
    check_px("f369 (734,334)", 11'd734, 11'd334, c_RED);
    check_px("f369 (733,334)", 11'd733, 11'd334, c_BLACK);
    check_px("f369 (797,334)", 11'd797, 11'd334, c_RED);
    check_px("f369 (798,334)", 11'd798, 11'd334, c_BLACK);
    check_px("f369 (0,5)",     11'd0,   11'd5,   c_WHITE);

    // Reset, then reach mode 2 with box at (100,100)
    rst = 1'b1;
    step();
    rst = 1'b0;
    frame_end(1'b1);
    frame_end(1'b1);                                            // mode 2, box (4,4)
    step();
    check_px("post-rst (4,4)", 11'd4, 11'd4, c_RED);
    check_px("post-rst (3,4)", 11'd3, 11'd4, c_BLACK);
    run_frames(48);                                             // box (100,100)
    check_px("box (100,100)", 11'd100, 11'd100, c_RED);

    // Mid-frame reset with a frame end already in stage 1
    drive(1'b1, 11'd120, 11'd300, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 11'd799, 11'd599, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 11'd110, 11'd110, 1'b0, 1'b0, 1'b1);
    step();
    check_reset_outs("midrst c0");
    step();
    check_reset_outs("midrst c1");
    rst = 1'b0;
    check_px("after rst mode0", 11'd100, 11'd0, c_YELLOW);
    frame_end_timed("fe after rst", 1'b0);
    check_px("rst step ignored", 11'd100, 11'd0, c_YELLOW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
